// File: rtl/branch_ctrl.sv
// EX-stage branch resolution: decides the real next PC, and drives a registered redirect/flush handshake to IF.
// Optional 2-bit direction table enabled by defining BRANCH_CTRL_BHT_EN.

module brcomp #(
  parameter int DATAW = 32
) (
  input  logic [2:0]       funct3,
  input  logic [DATAW-1:0] a,
  input  logic [DATAW-1:0] b,
  output logic             taken
);

  // Conditional-branch condition decode; unsupported funct3 values never take.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = (a == b);
      3'b001:  taken = (a != b);
      3'b100:  taken = ($signed(a) <  $signed(b));
      3'b101:  taken = ($signed(a) >= $signed(b));
      3'b110:  taken = (a <  b);
      3'b111:  taken = (a >= b);
      default: taken = 1'b0;
    endcase
  end

endmodule

module branch_ctrl #(
  parameter int DATAW    = 32,
  parameter int BHT_IDXW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic             ex_is_br,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic [2:0]       ex_funct3,
  input  logic [DATAW-1:0] ex_rs1,
  input  logic [DATAW-1:0] ex_rs2,
  input  logic [DATAW-1:0] ex_pc,
  input  logic [DATAW-1:0] ex_imm,
  input  logic [DATAW-1:0] ex_pred_pc,
  input  logic [DATAW-1:0] if_pc,
  output logic             if_pred_taken,
  output logic             redirect_valid,
  output logic [DATAW-1:0] redirect_pc,
  input  logic             redirect_ready,
  output logic             flush,
  output logic [31:0]      br_count,
  output logic [31:0]      mispred_count
);

  typedef enum logic {IDLE = 1'b0, REDIR = 1'b1} state_t;

  state_t           state_r, state_next_s;
  logic             cmp_taken_s, taken_s, accept_s, mispredict_s;
  logic [DATAW-1:0] target_s, actual_pc_s;
  logic             redirect_valid_r, flush_r;
  logic [DATAW-1:0] redirect_pc_r;
  logic [31:0]      br_count_r, mispred_count_r;

  brcomp #(.DATAW(DATAW)) u_brcomp (
    .funct3 (ex_funct3),
    .a      (ex_rs1),
    .b      (ex_rs2),
    .taken  (cmp_taken_s)
  );

  // Resolve the EX control transfer and compare against the path IF followed.
  always_comb begin
    accept_s    = ex_valid & ~ex_stall & (ex_is_br | ex_is_jal | ex_is_jalr) & (state_r == IDLE);
    taken_s     = ex_is_jal | ex_is_jalr | (ex_is_br & cmp_taken_s);
    if (ex_is_jalr) begin
      target_s = (ex_rs1 + ex_imm) & {{(DATAW-1){1'b1}}, 1'b0};
    end else begin
      target_s = ex_pc + ex_imm;
    end
    actual_pc_s  = taken_s ? target_s : (ex_pc + DATAW'(4));
    mispredict_s = accept_s & (actual_pc_s != ex_pred_pc);
  end

  // Next-state logic for the redirect handshake.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = mispredict_s ? REDIR : IDLE;
      REDIR:   state_next_s = (redirect_valid_r & redirect_ready) ? IDLE : REDIR;
      default: state_next_s = IDLE;
    endcase
  end

  // State register plus registered redirect/flush outputs and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r          <= IDLE;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= '0;
      flush_r          <= 1'b0;
      br_count_r       <= 32'd0;
      mispred_count_r  <= 32'd0;
    end else begin
      state_r <= state_next_s;
      flush_r <= mispredict_s;
      if (mispredict_s) begin
        redirect_valid_r <= 1'b1;
        redirect_pc_r    <= actual_pc_s;
        mispred_count_r  <= mispred_count_r + 32'd1;
      end else if (redirect_valid_r & redirect_ready) begin
        redirect_valid_r <= 1'b0;
      end
      if (accept_s) begin
        br_count_r <= br_count_r + 32'd1;
      end
    end
  end

  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;
  assign flush          = flush_r;
  assign br_count       = br_count_r;
  assign mispred_count  = mispred_count_r;

`ifdef BRANCH_CTRL_BHT_EN
  localparam int BHT_N = 2 ** BHT_IDXW;

  logic [1:0]          bht_r [BHT_N];
  logic [BHT_IDXW-1:0] upd_idx_s, look_idx_s;
  logic                unused_s;

  assign upd_idx_s     = ex_pc[BHT_IDXW+1:2];
  assign look_idx_s    = if_pc[BHT_IDXW+1:2];
  assign if_pred_taken = bht_r[look_idx_s][1];
  assign unused_s      = ^{if_pc[DATAW-1:BHT_IDXW+2], if_pc[1:0]};

  // Saturating direction counters, trained only by accepted conditional branches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) begin
        bht_r[i] <= 2'b01;
      end
    end else if (accept_s & ex_is_br) begin
      if (taken_s && (bht_r[upd_idx_s] != 2'b11)) begin
        bht_r[upd_idx_s] <= bht_r[upd_idx_s] + 2'b01;
      end else if (!taken_s && (bht_r[upd_idx_s] != 2'b00)) begin
        bht_r[upd_idx_s] <= bht_r[upd_idx_s] - 2'b01;
      end
    end
  end
`else
  logic unused_s;
  assign unused_s      = ^if_pc;
  assign if_pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: a spec-level model queues expected redirects, a monitor checks them.
// Define BRANCH_CTRL_BHT_EN for both RTL and bench to exercise the direction table.

module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_stall, ex_is_br, ex_is_jal, ex_is_jalr;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1, ex_rs2, ex_pc, ex_imm, ex_pred_pc, if_pc;
  logic        if_pred_taken, redirect_valid, redirect_ready, flush;
  logic [31:0] redirect_pc, br_count, mispred_count;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];
  bit          pend_m;
  int unsigned brc_m, misc_m;
  int          bht_m[16];
  logic [31:0] held_pc;

  branch_ctrl dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_is_br(ex_is_br), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_pred_pc(ex_pred_pc), .if_pc(if_pc),
    .if_pred_taken(if_pred_taken), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready), .flush(flush),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    exp_q.delete();
    pend_m = 1'b0;
    brc_m  = 0;
    misc_m = 0;
    for (int i = 0; i < 16; i++) bht_m[i] = 1;
  endtask

  // One EX cycle: drive, predict the outcome from the architectural rules, then step the clock.
  task automatic issue(input bit v, input bit st, input bit br, input bit jal, input bit jalr,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] pred,
                       input logic [31:0] ipc, input bit rdy);
    bit          acc, tk, pend_n;
    logic [31:0] tgt, act;
    int          idx, bht_n;
    ex_valid = v; ex_stall = st; ex_is_br = br; ex_is_jal = jal; ex_is_jalr = jalr;
    ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b; ex_pc = pc; ex_imm = imm;
    ex_pred_pc = pred; if_pc = ipc; redirect_ready = rdy;
    acc = v && !st && (br || jal || jalr) && !pend_m;
    tk  = jal || jalr || (br && ref_taken(f3, a, b));
    tgt = jalr ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
    act = tk ? tgt : pc + 32'd4;
    pend_n = pend_m && !rdy;
    idx = int'(pc[5:2]);
    bht_n = bht_m[idx];
    if (acc) begin
      if (act != pred) begin
        exp_q.push_back(act);
        pend_n = 1'b1;
      end
      if (br) bht_n = tk ? ((bht_n < 3) ? bht_n + 1 : 3) : ((bht_n > 0) ? bht_n - 1 : 0);
    end
    @(posedge clk);
    #1;
    pend_m     = pend_n;
    bht_m[idx] = bht_n;
    if (acc) begin
      brc_m++;
      if (act != pred) misc_m++;
    end
  endtask

  task automatic idle_cycle(input bit rdy);
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, if_pc, rdy);
  endtask

  // Monitor: pop the scoreboard on each flush, and track handshake state, counters and prediction.
  always @(negedge clk) begin
    if (!rst) begin
      if (flush) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_flush: got flush=1 expected no redirect at %0t", $time);
        end else begin
          chk("redirect_pc", redirect_pc, exp_q.pop_front());
        end
        held_pc = redirect_pc;
      end else if (redirect_valid) begin
        chk("redirect_hold", redirect_pc, held_pc);
      end
      chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, pend_m});
      chk("br_count", br_count, brc_m);
      chk("mispred_count", mispred_count, misc_m);
`ifdef BRANCH_CTRL_BHT_EN
      chk("if_pred_taken", {31'd0, if_pred_taken}, {31'd0, bht_m[int'(if_pc[5:2])] >= 2});
`else
      chk("if_pred_taken", {31'd0, if_pred_taken}, 32'd0);
`endif
    end
  end

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_stall = 1'b0; ex_is_br = 1'b0; ex_is_jal = 1'b0; ex_is_jalr = 1'b0;
    ex_funct3 = 3'd0; ex_rs1 = 32'd0; ex_rs2 = 32'd0; ex_pc = 32'd0; ex_imm = 32'd0;
    ex_pred_pc = 32'd0; if_pc = 32'd0; redirect_ready = 1'b0; held_pc = 32'd0;
    model_reset();
    #2;
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_br_count", br_count, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Correctly predicted BEQ, then BNE mispredict held with ready low.
    issue(1, 0, 1, 0, 0, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 32'h120, 32'h0, 0);
    issue(1, 0, 1, 0, 0, 3'd1, 32'd5, 32'd5, 32'h100, 32'h20, 32'h120, 32'h0, 0);
    // Wrong-path branches and a stalled branch while the redirect is pending.
    issue(1, 0, 1, 0, 0, 3'd1, 32'd5, 32'd5, 32'h200, 32'h20, 32'h0,   32'h0, 0);
    issue(1, 1, 0, 1, 0, 3'd0, 32'd0, 32'd0, 32'h300, 32'h40, 32'h0,   32'h0, 0);
    issue(1, 0, 0, 0, 1, 3'd0, 32'd7, 32'd0, 32'h400, 32'h8,  32'h0,   32'h0, 0);
    issue(1, 0, 1, 0, 0, 3'd1, 32'd5, 32'd5, 32'h200, 32'h20, 32'h0,   32'h0, 1);
    // Stalled mispredicting branch in IDLE is ignored.
    issue(1, 1, 1, 0, 0, 3'd1, 32'd5, 32'd5, 32'h200, 32'h20, 32'h0,   32'h0, 0);
    // JALR clears bit 0; BLT signed taken, BLTU not taken.
    issue(1, 0, 0, 0, 1, 3'd0, 32'h1001, 32'd0, 32'h500, 32'd2, 32'h1004, 32'h0, 1);
    idle_cycle(1);
    issue(1, 0, 1, 0, 0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h600, 32'h80, 32'h604, 32'h0, 1);
    idle_cycle(1);
    issue(1, 0, 1, 0, 0, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h600, 32'h80, 32'h680, 32'h0, 1);
    idle_cycle(1);

    // Reset between clock edges while a redirect is pending.
    issue(1, 0, 0, 1, 0, 3'd0, 32'd0, 32'd0, 32'h700, 32'h10, 32'h704, 32'h0, 0);
    idle_cycle(0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("midrst_redirect_pc", redirect_pc, 32'd0);
    chk("midrst_flush", {31'd0, flush}, 32'd0);
    chk("midrst_br_count", br_count, 32'd0);
    chk("midrst_mispred_count", mispred_count, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    issue(1, 0, 1, 0, 0, 3'd0, 32'd1, 32'd2, 32'h100, 32'h20, 32'h120, 32'h0, 1);
    idle_cycle(1);

`ifdef BRANCH_CTRL_BHT_EN
    // Train the entry for pc 0x40 up, then down past zero.
    issue(1, 0, 1, 0, 0, 3'd0, 32'd3, 32'd3, 32'h40, 32'h10, 32'h50, 32'h40, 1);
    issue(1, 0, 1, 0, 0, 3'd0, 32'd3, 32'd3, 32'h40, 32'h10, 32'h50, 32'h40, 1);
    chk("bht_taken", {31'd0, if_pred_taken}, 32'd1);
    repeat (4) issue(1, 0, 1, 0, 0, 3'd1, 32'd3, 32'd3, 32'h40, 32'h10, 32'h44, 32'h40, 1);
    chk("bht_not_taken", {31'd0, if_pred_taken}, 32'd0);
    issue(1, 0, 1, 0, 0, 3'd0, 32'd3, 32'd3, 32'h40, 32'h10, 32'h50, 32'h40, 1);
    chk("bht_floor", {31'd0, if_pred_taken}, 32'd0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [2:0]  f3;
      logic [31:0] a, b, pc, imm, pred;
      int          kind;
      bit          jal, jalr;
      f3   = 3'($urandom_range(0, 5));
      f3   = (f3 >= 3'd2) ? f3 + 3'd2 : f3;
      a    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3)) - 32'd1;
      b    = ($urandom_range(0, 1) == 0) ? a : 32'($urandom_range(0, 3)) - 32'd1;
      pc   = {$urandom} & 32'h0000_FFFC;
      imm  = 32'($signed(16'($urandom))) & 32'hFFFF_FFFE;
      kind = $urandom_range(0, 9);
      jal  = (kind == 6) || (kind == 7);
      jalr = (kind == 8);
      case ($urandom_range(0, 3))
        0:       pred = pc + 32'd4;
        1:       pred = pc + imm;
        2:       pred = ((a + imm) & 32'hFFFF_FFFE);
        default: pred = $urandom;
      endcase
      issue($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, kind < 6, jal, jalr,
            f3, a, b, pc, imm, pred, {$urandom} & 32'h0000_003C, $urandom_range(0, 2) == 0);
    end

    repeat (3) idle_cycle(1);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
